// File: rtl/vec3.sv
// Shared 3-component vector type and a pipelined normalizer producing Q1.14 unit vectors.
// Inputs are plain signed integers of any scale; the output direction is what matters.
package vec3_pkg;
    localparam int VEC3_W                 = 16;
    localparam int VEC3_FRAC_W            = 14;
    localparam int VEC3_NORMALIZE_LATENCY = 6;

    typedef logic signed [VEC3_W-1:0] vec3_comp_t;

    typedef struct packed {
        vec3_comp_t x;
        vec3_comp_t y;
        vec3_comp_t z;
    } vec3;
endpackage

module vec3_normalize
    import vec3_pkg::*;
(
    input  logic clk,
    input  vec3  src,
    output vec3  unit
);
    localparam int MAG_W  = VEC3_W;
    localparam int SUM_W  = 2 * VEC3_W;
    localparam int RAD_W  = SUM_W + 8;
    localparam int ROOT_W = RAD_W / 2;
    localparam int NUM_W  = MAG_W + VEC3_FRAC_W + 4;

    // Digit-by-digit square root; radicand is pre-scaled by 2^8 so the root has 4 fraction bits.
    function automatic logic [ROOT_W-1:0] isqrt(input logic [RAD_W-1:0] rad);
        logic [RAD_W-1:0] rem;
        logic [RAD_W-1:0] root;
        logic [RAD_W-1:0] bit_w;
        rem   = rad;
        root  = '0;
        bit_w = RAD_W'(1) << (RAD_W - 2);
        for (int i = 0; i < ROOT_W; i++) begin
            if (rem >= root + bit_w) begin
                rem  = rem - (root + bit_w);
                root = (root >> 1) + bit_w;
            end else begin
                root = root >> 1;
            end
            bit_w = bit_w >> 2;
        end
        return root[ROOT_W-1:0];
    endfunction

    function automatic logic [NUM_W-1:0] rnd_div(input logic [MAG_W-1:0] mag,
                                                 input logic [ROOT_W-1:0] root);
        logic [NUM_W-1:0] num;
        logic [NUM_W-1:0] den;
        num = NUM_W'(mag) << (VEC3_FRAC_W + 4);
        den = NUM_W'(root);
        if (root == '0) return '0;
        return (num + (den >> 1)) / den;
    endfunction

    function automatic vec3_comp_t sat_sign(input logic [NUM_W-1:0] quo, input logic neg);
        logic [NUM_W-1:0] lim;
        logic [NUM_W-1:0] clipped;
        lim     = NUM_W'(1) << VEC3_FRAC_W;
        clipped = (quo > lim) ? lim : quo;
        return neg ? -vec3_comp_t'(clipped[VEC3_W-1:0]) : vec3_comp_t'(clipped[VEC3_W-1:0]);
    endfunction

    vec3_comp_t        comp [3];
    logic [MAG_W-1:0]  mag_p0 [3];
    logic              neg_p0 [3];
    logic [SUM_W-1:0]  sum_p1;
    logic [MAG_W-1:0]  mag_p1 [3];
    logic              neg_p1 [3];
    logic [ROOT_W-1:0] root_p2;
    logic [MAG_W-1:0]  mag_p2 [3];
    logic              neg_p2 [3];
    logic [NUM_W-1:0]  quo_p3 [3];
    logic              neg_p3 [3];
    vec3_comp_t        res_p4 [3];
    vec3               out_p5;

    assign comp[0] = src.x;
    assign comp[1] = src.y;
    assign comp[2] = src.z;

    // p0: split into sign and magnitude
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            mag_p0[k] <= comp[k][VEC3_W-1] ? MAG_W'(-comp[k]) : MAG_W'(comp[k]);
            neg_p0[k] <= comp[k][VEC3_W-1];
        end
    end

    // p1: squared length
    always_ff @(posedge clk) begin
        sum_p1 <= SUM_W'(mag_p0[0]) * SUM_W'(mag_p0[0])
                + SUM_W'(mag_p0[1]) * SUM_W'(mag_p0[1])
                + SUM_W'(mag_p0[2]) * SUM_W'(mag_p0[2]);
        mag_p1 <= mag_p0;
        neg_p1 <= neg_p0;
    end

    // p2: length with 4 fraction bits
    always_ff @(posedge clk) begin
        root_p2 <= isqrt(RAD_W'(sum_p1) << 8);
        mag_p2  <= mag_p1;
        neg_p2  <= neg_p1;
    end

    // p3: rounded magnitude / length
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            quo_p3[k] <= rnd_div(mag_p2[k], root_p2);
        end
        neg_p3 <= neg_p2;
    end

    // p4: clip to 1.0 and restore sign
    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            res_p4[k] <= sat_sign(quo_p3[k], neg_p3[k]);
        end
    end

    // p5: output register
    always_ff @(posedge clk) begin
        out_p5 <= '{x: res_p4[0], y: res_p4[1], z: res_p4[2]};
    end

    assign unit = out_p5;
endmodule

// File: rtl/vec3_normalize_arbiter_pkg.sv
// Constants and helpers shared by the normalizer arbiter and its interface.
package vec3_normalize_arbiter_pkg;
    localparam int N_REQ_MAX   = 16;
    localparam int IN_FLIGHT_W = 3;
    localparam int COUNT_W     = 4;

    // A fully packed pipeline holds one more request than the reported count can show.
    function automatic logic [IN_FLIGHT_W-1:0] clamp_in_flight(input logic [COUNT_W-1:0] count);
        return (count > COUNT_W'((1 << IN_FLIGHT_W) - 1)) ? '1 : count[IN_FLIGHT_W-1:0];
    endfunction
endpackage

// File: rtl/vec3_normalize_arbiter_if.sv
// Request/result bundle between the requesters (master) and the shared normalizer (slave).
interface vec3_normalize_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    import vec3_pkg::*;
    import vec3_normalize_arbiter_pkg::*;

    logic [N_REQ-1:0]       req_valid_in;
    vec3  [N_REQ-1:0]       req_vec_in;
    logic [N_REQ-1:0]       req_ready_out;
    logic [N_REQ-1:0]       res_valid_out;
    vec3                    res_vec_out;
    logic [ID_W-1:0]        res_id_out;
    logic                   res_zero_out;
    logic [IN_FLIGHT_W-1:0] in_flight_out;

    modport master (
        output req_valid_in, req_vec_in,
        input  req_ready_out, res_valid_out, res_vec_out, res_id_out, res_zero_out, in_flight_out
    );

    modport slave (
        input  req_valid_in, req_vec_in,
        output req_ready_out, res_valid_out, res_vec_out, res_id_out, res_zero_out, in_flight_out
    );
endinterface

// File: rtl/vec3_normalize_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr, pointer moves past the winner.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W:0]   cursor;
    logic [IDX_W-1:0] sel;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cursor    = '0;
        sel       = '0;
        for (int off = 0; off < N; off++) begin
            cursor = {1'b0, rr_ptr} + (IDX_W + 1)'(off);
            if (cursor >= (IDX_W + 1)'(N)) cursor = cursor - (IDX_W + 1)'(N);
            sel = cursor[IDX_W-1:0];
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant_idx  = sel;
                grant[sel] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
endmodule

// File: rtl/vec3_normalize_arbiter.sv
// Shares one pipelined vec3_normalize among N_REQ requesters; a shadow pipeline carries
// each request's owner and zero flag so the result can be steered back as a one-cycle pulse.
module vec3_normalize_arbiter
    import vec3_pkg::*;
    import vec3_normalize_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input logic                     clk_in,
    input logic                     rst_n_in,
    vec3_normalize_arbiter_if.slave bus
);
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            zero;
    } shadow_t;

    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_idx;
    logic               accept;
    vec3                win_vec;
    logic               launch_valid;
    logic [ID_W-1:0]    launch_id;
    logic               launch_zero;
    vec3                launch_vec;
    shadow_t            shadow [VEC3_NORMALIZE_LATENCY];
    shadow_t            tail;
    vec3                norm_vec;
    logic               returned;
    logic [COUNT_W-1:0] count;

    rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_arb (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .req       (bus.req_valid_in),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Grants are suppressed while reset is held so nothing is accepted into a clearing pipeline.
    assign bus.req_ready_out = rst_n_in ? grant : '0;
    assign accept            = |(bus.req_valid_in & bus.req_ready_out);
    assign win_vec           = bus.req_vec_in[grant_idx];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            launch_valid <= 1'b0;
            launch_id    <= '0;
            launch_zero  <= 1'b0;
        end else begin
            launch_valid <= accept;
            if (accept) begin
                launch_id   <= grant_idx;
                launch_zero <= (win_vec.x == '0) && (win_vec.y == '0) && (win_vec.z == '0);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (accept) launch_vec <= win_vec;
    end

    vec3_normalize u_norm (
        .clk  (clk_in),
        .src  (launch_vec),
        .unit (norm_vec)
    );

    // Shadow tags advance in lockstep with the normalizer's data stages.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int s = 0; s < VEC3_NORMALIZE_LATENCY; s++) shadow[s] <= '0;
        end else begin
            shadow[0] <= '{valid: launch_valid, id: launch_id, zero: launch_zero};
            for (int s = 1; s < VEC3_NORMALIZE_LATENCY; s++) shadow[s] <= shadow[s-1];
        end
    end

    assign tail = shadow[VEC3_NORMALIZE_LATENCY-1];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bus.res_valid_out <= '0;
            bus.res_id_out    <= '0;
            bus.res_zero_out  <= 1'b0;
            bus.res_vec_out   <= '0;
        end else begin
            bus.res_valid_out <= tail.valid ? (N_REQ'(1) << tail.id) : '0;
            bus.res_id_out    <= tail.id;
            bus.res_zero_out  <= tail.zero & tail.valid;
            bus.res_vec_out   <= norm_vec;
        end
    end

    assign returned = |bus.res_valid_out;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count <= '0;
        end else begin
            case ({accept, returned})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.in_flight_out = clamp_in_flight(count);
endmodule

// File: tb/tb_vec3_normalize_arbiter.sv
// Directed bench for vec3_normalize_arbiter with four requesters and hand-computed Q1.14 results.
module tb_vec3_normalize_arbiter;
    import vec3_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   cnt0;
    int   cnt2;
    logic [3:0] exp_mask;
    vec3  vec_tab [N];
    int   ex [N];
    int   ey [N];
    int   ez [N];

    vec3_normalize_arbiter_if #(.N_REQ(N)) bus ();

    vec3_normalize_arbiter #(.N_REQ(N)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_near(input string tag, input vec3_comp_t obs, input int exp);
        int diff;
        diff = int'(obs) - exp;
        total++;
        assert (!$isunknown(obs) && diff >= -2 && diff <= 2) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (+-2)", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input int x, input int y, input int z);
        check_near({tag, "_x"}, bus.res_vec_out.x, x);
        check_near({tag, "_y"}, bus.res_vec_out.y, y);
        check_near({tag, "_z"}, bus.res_vec_out.z, z);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  bus.req_ready_out, 0);
        check({tag, "_valid"},  bus.res_valid_out, 0);
        check({tag, "_vec"},    bus.res_vec_out,   0);
        check({tag, "_id"},     bus.res_id_out,    0);
        check({tag, "_zero"},   bus.res_zero_out,  0);
        check({tag, "_flight"}, bus.in_flight_out, 0);
    endtask

    function automatic vec3 mk(input int x, input int y, input int z);
        return '{x: vec3_comp_t'(x), y: vec3_comp_t'(y), z: vec3_comp_t'(z)};
    endfunction

    initial begin
        vec_tab[0] = mk(3, 0, 4);  ex[0] = 9830;  ey[0] = 0;      ez[0] = 13107;
        vec_tab[1] = mk(0, 5, 0);  ex[1] = 0;     ey[1] = 16384;  ez[1] = 0;
        vec_tab[2] = mk(0, 0, -7); ex[2] = 0;     ey[2] = 0;      ez[2] = -16384;
        vec_tab[3] = mk(4, -3, 0); ex[3] = 13107; ey[3] = -9830;  ez[3] = 0;

        rst_n = 1'b0;
        bus.req_valid_in = 4'b1111;
        for (int i = 0; i < N; i++) bus.req_vec_in[i] = vec_tab[i];
        #12;
        check_all_zero("reset");
        bus.req_valid_in = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;

        // All four contend from the first cycle after reset.
        for (int c = 0; c < 17; c++) begin
            bus.req_valid_in = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) begin
                exp_mask = 4'b0001 << (c % 4);
                check($sformatf("contend_grant_c%0d", c), bus.req_ready_out, exp_mask);
                check($sformatf("contend_quiet_c%0d", c), bus.res_valid_out, 0);
            end else if (c < 16) begin
                exp_mask = 4'b0001 << ((c - 8) % 4);
                check($sformatf("contend_pulse_c%0d", c), bus.res_valid_out, exp_mask);
                check($sformatf("contend_id_c%0d", c), bus.res_id_out, (c - 8) % 4);
                check_vec($sformatf("contend_vec_c%0d", c), ex[(c - 8) % 4], ey[(c - 8) % 4],
                          ez[(c - 8) % 4]);
            end else begin
                check("contend_drained_valid", bus.res_valid_out, 0);
                check("contend_drained_flight", bus.in_flight_out, 0);
            end
            tick();
        end

        // Requesters 0 and 2 share the unit evenly.
        cnt0 = 0;
        cnt2 = 0;
        for (int c = 0; c < 20; c++) begin
            bus.req_valid_in = 4'b0101;
            #1;
            exp_mask = (c % 2 == 0) ? 4'b0001 : 4'b0100;
            check($sformatf("fair_grant_c%0d", c), bus.req_ready_out, exp_mask);
            if (bus.req_ready_out[0]) cnt0++;
            if (bus.req_ready_out[2]) cnt2++;
            tick();
        end
        bus.req_valid_in = 4'b0000;
        check("fair_count0", cnt0, 10);
        check("fair_count2", cnt2, 10);
        repeat (7) tick();
        check("fair_last_pulse", bus.res_valid_out, 4'b0100);
        tick();
        check("fair_drained_valid", bus.res_valid_out, 0);
        check("fair_drained_flight", bus.in_flight_out, 0);

        // Single request from requester 1 with (3,0,4).
        bus.req_vec_in[1] = mk(3, 0, 4);
        bus.req_valid_in  = 4'b0010;
        #1;
        check("single_grant", bus.req_ready_out, 4'b0010);
        tick();
        bus.req_valid_in = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("single_flight_k%0d", k), bus.in_flight_out, 1);
            if (k < 8) begin
                check($sformatf("single_quiet_k%0d", k), bus.res_valid_out, 0);
            end else begin
                check("single_pulse", bus.res_valid_out, 4'b0010);
                check("single_id", bus.res_id_out, 1);
                check("single_zero", bus.res_zero_out, 0);
                check_vec("single_vec", 9830, 0, 13107);
            end
            tick();
        end
        check("single_after_valid", bus.res_valid_out, 0);
        check("single_after_flight", bus.in_flight_out, 0);

        // Zero vector from requester 3, then a normal vector from requester 0.
        bus.req_vec_in[3] = mk(0, 0, 0);
        bus.req_valid_in  = 4'b1000;
        #1;
        check("zero_grant", bus.req_ready_out, 4'b1000);
        tick();
        bus.req_valid_in = 4'b0001;
        tick();
        bus.req_valid_in = 4'b0000;
        repeat (6) tick();
        check("zero_pulse", bus.res_valid_out, 4'b1000);
        check("zero_flag", bus.res_zero_out, 1);
        check("zero_id", bus.res_id_out, 3);
        tick();
        check("zero_next_pulse", bus.res_valid_out, 4'b0001);
        check("zero_next_flag", bus.res_zero_out, 0);
        check_vec("zero_next_vec", 9830, 0, 13107);
        tick();
        check("zero_after_flight", bus.in_flight_out, 0);

        // Requests in cycles 0, 2 and 3 only.
        for (int c = 0; c < 13; c++) begin
            case (c)
                0:       bus.req_valid_in = 4'b0100;
                2:       bus.req_valid_in = 4'b0001;
                3:       bus.req_valid_in = 4'b0010;
                default: bus.req_valid_in = 4'b0000;
            endcase
            #1;
            exp_mask = (c == 8) ? 4'b0100 : (c == 10) ? 4'b0001 : (c == 11) ? 4'b0010 : 4'b0000;
            check($sformatf("gap_pulse_c%0d", c), bus.res_valid_out, exp_mask);
            if (c == 8) check_vec("gap_vec_c8", 0, 0, -16384);
            tick();
        end

        // Reset while five requests are in flight.
        bus.req_vec_in[1] = vec_tab[1];
        bus.req_vec_in[3] = vec_tab[3];
        bus.req_valid_in  = 4'b1111;
        repeat (5) tick();
        check("midrst_flight_before", bus.in_flight_out, 5);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst_held");
        tick();
        tick();
        check_all_zero("midrst_held_later");
        bus.req_valid_in = 4'b0000;
        rst_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            #1;
            check($sformatf("midrst_nopulse_k%0d", k), bus.res_valid_out, 0);
            check($sformatf("midrst_flight_k%0d", k), bus.in_flight_out, 0);
            tick();
        end
        bus.req_valid_in = 4'b1111;
        #1;
        check("midrst_first_grant", bus.req_ready_out, 4'b0001);
        tick();
        bus.req_valid_in = 4'b0000;
        repeat (7) tick();
        check("midrst_first_pulse", bus.res_valid_out, 4'b0001);
        check("midrst_first_id", bus.res_id_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
